// File: rtl/id_hazard_ctrl_pkg.sv
// Shared decode-stage definitions: instruction marks, hazard FSM states and
// the HI/LO-touching instruction predicate used by the hazard controller.
package id_hazard_ctrl_pkg;

  localparam logic [7:0] INST_NOP   = 8'h00;
  localparam logic [7:0] INST_ADDU  = 8'h01;
  localparam logic [7:0] INST_SUBU  = 8'h02;
  localparam logic [7:0] INST_LW    = 8'h03;
  localparam logic [7:0] INST_SW    = 8'h04;
  localparam logic [7:0] INST_MFHI  = 8'h10;
  localparam logic [7:0] INST_MFLO  = 8'h11;
  localparam logic [7:0] INST_MTHI  = 8'h12;
  localparam logic [7:0] INST_MTLO  = 8'h13;
  localparam logic [7:0] INST_MULT  = 8'h14;
  localparam logic [7:0] INST_MULTU = 8'h15;
  localparam logic [7:0] INST_DIV   = 8'h16;
  localparam logic [7:0] INST_DIVU  = 8'h17;

  typedef enum logic {
    HZ_STATE_RUN   = 1'b0,
    HZ_STATE_FLUSH = 1'b1
  } hz_state_e;

  // True for every instruction that reads or writes HI/LO or starts the mul/div unit.
  function automatic logic inst_is_hilo(input logic [7:0] inst);
    case (inst)
      INST_MFHI, INST_MFLO, INST_MTHI, INST_MTLO,
      INST_MULT, INST_MULTU, INST_DIV, INST_DIVU: inst_is_hilo = 1'b1;
      default:                                    inst_is_hilo = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_hazard_ctrl_if.sv
// Bundle between decode/EX/MEM state and the hazard controller's pipeline
// register controls; state is a debug view of the hazard FSM.
interface id_hazard_ctrl_if;
  import id_hazard_ctrl_pkg::*;

  // id_valid qualifies every id_* field: when low the IF/ID register holds a
  // bubble and none of the decode fields may raise a hazard.
  logic       id_valid;
  logic [7:0] id_inst;
  logic [4:0] id_reg_s;
  logic [4:0] id_reg_t;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       ex_mem_read;
  logic [4:0] ex_reg_dst;
  logic       ex_muldiv_start;
  logic       mem_busy;
  logic       exception;

  logic       stall_if;
  logic       stall_id;
  logic       bubble_ex;
  logic       stall_ex;
  logic       flush_id;
  logic       flush_ex;
  logic       muldiv_busy;
  logic       muldiv_abort;
  hz_state_e  state;

  modport master (
    output id_valid, id_inst, id_reg_s, id_reg_t, id_uses_rs, id_uses_rt,
           ex_mem_read, ex_reg_dst, ex_muldiv_start, mem_busy, exception,
    input  stall_if, stall_id, bubble_ex, stall_ex, flush_id, flush_ex,
           muldiv_busy, muldiv_abort, state
  );

  modport slave (
    input  id_valid, id_inst, id_reg_s, id_reg_t, id_uses_rs, id_uses_rt,
           ex_mem_read, ex_reg_dst, ex_muldiv_start, mem_busy, exception,
    output stall_if, stall_id, bubble_ex, stall_ex, flush_id, flush_ex,
           muldiv_busy, muldiv_abort, state
  );

endinterface

// File: rtl/id_hazard_ctrl_muldiv_timer.sv
// Occupancy timer for the multi-cycle mul/div unit: loads on a start pulse,
// counts down to zero, and is cleared (with an abort pulse) by an exception.
module muldiv_timer #(
  parameter int unsigned CYCLES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic clear,
  output logic busy,
  output logic abort
);

  localparam int unsigned CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;

  logic [CW-1:0] cnt;

  // Clear wins over start so a mul/div issued alongside an exception never runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CW'(CYCLES - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign busy  = (cnt != '0);
  assign abort = clear & busy;

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard controller: load-use and HI/LO interlocks, memory
// freezes and exception flush sequencing for the IF/ID, ID/EX, EX/MEM registers.
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULDIV_CYCLES = 32,
  parameter int unsigned FLUSH_CYCLES  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  id_hazard_ctrl_if.slave   bus
);

  localparam int unsigned FW = $clog2(FLUSH_CYCLES + 1);

  hz_state_e     state;
  hz_state_e     state_next;
  logic [FW-1:0] flush_cnt;
  logic [FW-1:0] flush_cnt_next;

  logic md_busy;
  logic md_abort;
  logic lu;
  logic md;

  logic stall_if;
  logic stall_id;
  logic bubble_ex;
  logic stall_ex;
  logic flush_id;
  logic flush_ex;
  logic muldiv_abort;

  muldiv_timer #(
    .CYCLES (MULDIV_CYCLES)
  ) u_muldiv_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (bus.ex_muldiv_start),
    .clear (bus.exception),
    .busy  (md_busy),
    .abort (md_abort)
  );

  // Register 0 is hardwired, so a load targeting it can never create a hazard.
  assign lu = bus.id_valid & bus.ex_mem_read & (bus.ex_reg_dst != 5'd0) &
              ((bus.id_uses_rs & (bus.id_reg_s == bus.ex_reg_dst)) |
               (bus.id_uses_rt & (bus.id_reg_t == bus.ex_reg_dst)));

  assign md = bus.id_valid & md_busy & inst_is_hilo(bus.id_inst);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HZ_STATE_RUN;
      flush_cnt <= '0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    if (bus.exception) begin
      state_next     = HZ_STATE_FLUSH;
      flush_cnt_next = FW'(FLUSH_CYCLES);
    end else if (state == HZ_STATE_FLUSH) begin
      if (flush_cnt <= FW'(1)) begin
        state_next     = HZ_STATE_RUN;
        flush_cnt_next = '0;
      end else begin
        flush_cnt_next = flush_cnt - FW'(1);
      end
    end
  end

  // Outputs are forced low while reset is asserted, regardless of live inputs.
  always_comb begin
    stall_if     = 1'b0;
    stall_id     = 1'b0;
    bubble_ex    = 1'b0;
    stall_ex     = 1'b0;
    flush_id     = 1'b0;
    flush_ex     = 1'b0;
    muldiv_abort = 1'b0;
    if (rst_n) begin
      if (bus.exception) begin
        flush_id     = 1'b1;
        flush_ex     = 1'b1;
        muldiv_abort = md_abort;
      end else if (state == HZ_STATE_FLUSH) begin
        flush_id = 1'b1;
      end else if (bus.mem_busy) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        stall_ex = 1'b1;
      end else if (lu | md) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end
    end
  end

  assign bus.stall_if     = stall_if;
  assign bus.stall_id     = stall_id;
  assign bus.bubble_ex    = bubble_ex;
  assign bus.stall_ex     = stall_ex;
  assign bus.flush_id     = flush_id;
  assign bus.flush_ex     = flush_ex;
  assign bus.muldiv_busy  = md_busy & rst_n;
  assign bus.muldiv_abort = muldiv_abort;
  assign bus.state        = state;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: load-use, mul/div interlock, memory
// freeze, exception flush and asynchronous reset scenarios.
module tb_id_hazard_ctrl;
  import id_hazard_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  id_hazard_ctrl_if bus ();

  id_hazard_ctrl #(
    .MULDIV_CYCLES (32),
    .FLUSH_CYCLES  (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // {stall_if, stall_id, bubble_ex, stall_ex, flush_id, flush_ex, muldiv_busy, muldiv_abort}
  logic [7:0] outs;
  assign outs = {bus.stall_if, bus.stall_id, bus.bubble_ex, bus.stall_ex,
                 bus.flush_id, bus.flush_ex, bus.muldiv_busy, bus.muldiv_abort};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.id_valid        = 1'b0;
    bus.id_inst         = INST_NOP;
    bus.id_reg_s        = 5'd0;
    bus.id_reg_t        = 5'd0;
    bus.id_uses_rs      = 1'b0;
    bus.id_uses_rt      = 1'b0;
    bus.ex_mem_read     = 1'b0;
    bus.ex_reg_dst      = 5'd0;
    bus.ex_muldiv_start = 1'b0;
    bus.mem_busy        = 1'b0;
    bus.exception       = 1'b0;
  endtask

  task automatic drive_id(input logic [7:0] inst, input logic [4:0] rs, input logic [4:0] rt,
                          input logic use_rs, input logic use_rt);
    bus.id_valid   = 1'b1;
    bus.id_inst    = inst;
    bus.id_reg_s   = rs;
    bus.id_reg_t   = rt;
    bus.id_uses_rs = use_rs;
    bus.id_uses_rt = use_rt;
  endtask

  task automatic drive_load(input logic [4:0] dst);
    bus.ex_mem_read = 1'b1;
    bus.ex_reg_dst  = dst;
  endtask

  task automatic start_muldiv();
    bus.ex_muldiv_start = 1'b1;
    next_cycle();
    bus.ex_muldiv_start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (outs !== 8'b0000_0000) begin
      errors++;
      $display("FAIL reset_outs got=%b exp=%b", outs, 8'b0000_0000);
    end
    checks++;
    if (bus.state !== HZ_STATE_RUN) begin
      errors++;
      $display("FAIL reset_state got=%0d exp=%0d", bus.state, HZ_STATE_RUN);
    end
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++;
    if (outs !== 8'b0000_0000) begin
      errors++;
      $display("FAIL post_reset_outs got=%b exp=%b", outs, 8'b0000_0000);
    end
  endtask

  task automatic test_load_use();
    next_cycle();
    drive_idle();
    drive_load(5'd3);
    drive_id(INST_ADDU, 5'd3, 5'd5, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (outs !== 8'b1110_0000) begin
      errors++;
      $display("FAIL lu_rs_stall got=%b exp=%b", outs, 8'b1110_0000);
    end
    // Bubble reaches ID/EX: EX no longer holds the load.
    next_cycle();
    bus.ex_mem_read = 1'b0;
    bus.ex_reg_dst  = 5'd0;
    @(negedge clk);
    checks++;
    if (outs !== 8'b0000_0000) begin
      errors++;
      $display("FAIL lu_release got=%b exp=%b", outs, 8'b0000_0000);
    end
    next_cycle();
    drive_load(5'd0);
    drive_id(INST_ADDU, 5'd0, 5'd0, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (outs !== 8'b0000_0000) begin
      errors++;
      $display("FAIL lu_r0 got=%b exp=%b", outs, 8'b0000_0000);
    end
    next_cycle();
    drive_load(5'd3);
    drive_id(INST_ADDU, 5'd7, 5'd3, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (outs !== 8'b0000_0000) begin
      errors++;
      $display("FAIL lu_rt_unused got=%b exp=%b", outs, 8'b0000_0000);
    end
    next_cycle();
    drive_id(INST_SW, 5'd7, 5'd3, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (outs !== 8'b1110_0000) begin
      errors++;
      $display("FAIL lu_rt_stall got=%b exp=%b", outs, 8'b1110_0000);
    end
    next_cycle();
    bus.id_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 8'b0000_0000) begin
      errors++;
      $display("FAIL lu_id_invalid got=%b exp=%b", outs, 8'b0000_0000);
    end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_muldiv();
    int n;
    n = 0;
    next_cycle();
    drive_idle();
    bus.ex_muldiv_start = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== 8'b0000_0000) begin
      errors++;
      $display("FAIL md_start_cycle got=%b exp=%b", outs, 8'b0000_0000);
    end
    next_cycle();
    bus.ex_muldiv_start = 1'b0;
    drive_id(INST_ADDU, 5'd1, 5'd2, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (outs !== 8'b0000_0010) begin
      errors++;
      $display("FAIL md_busy_nonhilo got=%b exp=%b", outs, 8'b0000_0010);
    end
    next_cycle();
    drive_id(INST_MFLO, 5'd0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.stall_if) break;
      n++;
      checks++;
      if (outs !== 8'b1110_0010) begin
        errors++;
        $display("FAIL md_stall_cycle%0d got=%b exp=%b", n, outs, 8'b1110_0010);
      end
      next_cycle();
    end
    checks++;
    if (n != 30) begin
      errors++;
      $display("FAIL md_stall_len got=%0d exp=%0d", n, 30);
    end
    checks++;
    if (outs !== 8'b0000_0000) begin
      errors++;
      $display("FAIL md_done got=%b exp=%b", outs, 8'b0000_0000);
    end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_exception();
    next_cycle();
    drive_idle();
    start_muldiv();
    next_cycle();
    next_cycle();
    drive_id(INST_MFLO, 5'd0, 5'd0, 1'b0, 1'b0);
    bus.mem_busy  = 1'b1;
    bus.exception = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== 8'b0000_1111) begin
      errors++;
      $display("FAIL exc_abort got=%b exp=%b", outs, 8'b0000_1111);
    end
    next_cycle();
    bus.exception = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 8'b0000_1000 || bus.state !== HZ_STATE_FLUSH) begin
      errors++;
      $display("FAIL exc_flush got=%b/%0d exp=%b/%0d", outs, bus.state, 8'b0000_1000, HZ_STATE_FLUSH);
    end
    next_cycle();
    bus.mem_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 8'b0000_0000 || bus.state !== HZ_STATE_RUN) begin
      errors++;
      $display("FAIL exc_return got=%b/%0d exp=%b/%0d", outs, bus.state, 8'b0000_0000, HZ_STATE_RUN);
    end
    // Back-to-back exceptions: the second one lands in FLUSH and reloads it.
    next_cycle();
    bus.exception = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++;
    if (outs !== 8'b0000_1100) begin
      errors++;
      $display("FAIL exc_in_flush got=%b exp=%b", outs, 8'b0000_1100);
    end
    next_cycle();
    bus.exception = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 8'b0000_1000) begin
      errors++;
      $display("FAIL exc_reload got=%b exp=%b", outs, 8'b0000_1000);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (outs !== 8'b0000_0000) begin
      errors++;
      $display("FAIL exc_reload_done got=%b exp=%b", outs, 8'b0000_0000);
    end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_mem_busy();
    next_cycle();
    drive_idle();
    drive_load(5'd9);
    drive_id(INST_SUBU, 5'd9, 5'd2, 1'b1, 1'b1);
    bus.mem_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== 8'b1101_0000) begin
        errors++;
        $display("FAIL mem_freeze%0d got=%b exp=%b", i, outs, 8'b1101_0000);
      end
      next_cycle();
    end
    bus.mem_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 8'b1110_0000) begin
      errors++;
      $display("FAIL mem_then_lu got=%b exp=%b", outs, 8'b1110_0000);
    end
    next_cycle();
    bus.ex_mem_read = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 8'b0000_0000) begin
      errors++;
      $display("FAIL mem_then_run got=%b exp=%b", outs, 8'b0000_0000);
    end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_reset_mid();
    next_cycle();
    drive_idle();
    start_muldiv();
    next_cycle();
    drive_id(INST_MFHI, 5'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (outs !== 8'b1110_0010) begin
      errors++;
      $display("FAIL rst_md_pre got=%b exp=%b", outs, 8'b1110_0010);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== 8'b0000_0000 || bus.state !== HZ_STATE_RUN) begin
      errors++;
      $display("FAIL rst_md_async got=%b/%0d exp=%b/%0d", outs, bus.state, 8'b0000_0000, HZ_STATE_RUN);
    end
    #1 rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++;
    if (outs !== 8'b0000_0000) begin
      errors++;
      $display("FAIL rst_md_after got=%b exp=%b", outs, 8'b0000_0000);
    end
    next_cycle();
    drive_idle();
    bus.exception = 1'b1;
    next_cycle();
    bus.exception = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 8'b0000_1000) begin
      errors++;
      $display("FAIL rst_fl_pre got=%b exp=%b", outs, 8'b0000_1000);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== 8'b0000_0000 || bus.state !== HZ_STATE_RUN) begin
      errors++;
      $display("FAIL rst_fl_async got=%b/%0d exp=%b/%0d", outs, bus.state, 8'b0000_0000, HZ_STATE_RUN);
    end
    #1 rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++;
    if (outs !== 8'b0000_0000 || bus.state !== HZ_STATE_RUN) begin
      errors++;
      $display("FAIL rst_fl_after got=%b/%0d exp=%b/%0d", outs, bus.state, 8'b0000_0000, HZ_STATE_RUN);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive_idle();
    test_reset();
    test_load_use();
    test_muldiv();
    test_exception();
    test_mem_busy();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
